// File: rtl/uart_report_pkg.sv
// uart_report_pkg: shared FSM states and constants for the UART count reporter
package uart_report_pkg;
    typedef enum logic [2:0] {IDLE, CONVERT, LOAD, LAUNCH, WAIT_DONE} state_t;
    localparam logic [7:0] ASCII_CR = 8'd13;
    localparam logic [7:0] ASCII_LF = 8'd10;
    localparam int NUM_DIGITS = 5;
    localparam int QUEUE_DEPTH = NUM_DIGITS + 2;
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble, one bit per cycle; done flags the final iteration cycle
module bin2bcd_seq
    import uart_report_pkg::*;
#(
    parameter int count_width = 16,
    parameter int num_digits  = NUM_DIGITS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [count_width-1:0]    bin,
    output logic                      done,
    output logic [num_digits*4-1:0]   bcd
);
    localparam int iter_w = $clog2(count_width + 1);
    logic [count_width-1:0]  shift;
    logic [iter_w-1:0]       iter;
    logic                    running;
    logic [num_digits*4-1:0] adj;

    // bcd is complete on the edge that ends the cycle where done is high
    assign done = running && (iter == iter_w'(count_width - 1));

    // add 3 to every nibble of 5 or more ahead of the shift
    always_comb begin
        adj = bcd;
        for (int i = 0; i < num_digits; i++)
            if (bcd[i*4 +: 4] > 4'd4) adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end

    // load on start, then shift one binary MSB into the BCD register per cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift   <= '0;
            bcd     <= '0;
            iter    <= '0;
            running <= 1'b0;
        end else if (start) begin
            shift   <= bin;
            bcd     <= '0;
            iter    <= '0;
            running <= 1'b1;
        end else if (running) begin
            bcd     <= {adj[num_digits*4-2:0], shift[count_width-1]};
            shift   <= shift << 1;
            iter    <= iter + iter_w'(1);
            running <= !done;
        end
    end
endmodule

// File: rtl/uart_count_reporter.sv
// uart_count_reporter: streams a count as a decimal ASCII line into UART TX (REPORT_CRLF_EN selects CR LF, else LF)
module uart_count_reporter
    import uart_report_pkg::*;
#(
    parameter int count_width = 16,
    parameter int data_width  = 8,
    parameter int ascii_zero  = 48
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   report_req,
    input  logic [count_width-1:0] count,
    input  logic                   tx_done,
    output logic                   tx_en,
    output logic [data_width-1:0]  data_tx,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   req_dropped
);
    localparam int ptr_w = $clog2(QUEUE_DEPTH + 1);
    typedef logic [data_width-1:0] byte_t;

    state_t                  state, state_d;
    byte_t                   queue [QUEUE_DEPTH];
    byte_t                   queue_d [QUEUE_DEPTH];
    byte_t                   load_q [QUEUE_DEPTH];
    logic [ptr_w-1:0]        len, len_d, ptr, ptr_d, nd, load_len;
    logic [NUM_DIGITS*4-1:0] bcd, aligned;
    logic                    conv_start, conv_done, accept;
    logic                    tx_en_d, busy_d, frame_done_d, req_dropped_d;
    byte_t                   data_tx_d;

    bin2bcd_seq #(.count_width(count_width), .num_digits(NUM_DIGITS)) u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (count),
        .done  (conv_done),
        .bcd   (bcd)
    );

    // frame image: digits from the leading nonzero one down to units, then the terminator
    always_comb begin
        nd = ptr_w'(1);
        for (int i = 1; i < NUM_DIGITS; i++)
            if (bcd[i*4 +: 4] != 4'd0) nd = ptr_w'(i + 1);
        aligned = bcd << (4 * (NUM_DIGITS - int'(nd)));
        for (int j = 0; j < QUEUE_DEPTH; j++) load_q[j] = '0;
        for (int j = 0; j < NUM_DIGITS; j++)
            if (ptr_w'(j) < nd)
                load_q[j] = byte_t'(ascii_zero) + byte_t'(aligned[(NUM_DIGITS-1-j)*4 +: 4]);
`ifdef REPORT_CRLF_EN
        load_q[nd]              = byte_t'(ASCII_CR);
        load_q[nd + ptr_w'(1)]  = byte_t'(ASCII_LF);
        load_len                = nd + ptr_w'(2);
`else
        load_q[nd]              = byte_t'(ASCII_LF);
        load_len                = nd + ptr_w'(1);
`endif
    end

    // next state and registered output values; a request in the frame_done cycle is still refused
    always_comb begin
        state_d       = state;
        queue_d       = queue;
        len_d         = len;
        ptr_d         = ptr;
        tx_en_d       = 1'b1;
        data_tx_d     = data_tx;
        frame_done_d  = 1'b0;
        conv_start    = 1'b0;
        accept        = report_req && (state == IDLE) && !frame_done;
        req_dropped_d = report_req && !accept;
        case (state)
            IDLE: begin
                conv_start = accept;
                state_d    = accept ? CONVERT : IDLE;
            end
            CONVERT: state_d = conv_done ? LOAD : CONVERT;
            LOAD: begin
                queue_d = load_q;
                len_d   = load_len;
                ptr_d   = '0;
                state_d = LAUNCH;
            end
            LAUNCH: begin
                tx_en_d   = 1'b0;
                data_tx_d = queue[ptr];
                state_d   = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    frame_done_d = (ptr == len - ptr_w'(1));
                    ptr_d        = frame_done_d ? ptr : ptr + ptr_w'(1);
                    state_d      = frame_done_d ? IDLE : LAUNCH;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // state, byte queue and all outputs are registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            queue       <= '{default: '0};
            len         <= '0;
            ptr         <= '0;
            tx_en       <= 1'b1;
            data_tx     <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            req_dropped <= 1'b0;
        end else begin
            state       <= state_d;
            queue       <= queue_d;
            len         <= len_d;
            ptr         <= ptr_d;
            tx_en       <= tx_en_d;
            data_tx     <= data_tx_d;
            busy        <= busy_d;
            frame_done  <= frame_done_d;
            req_dropped <= req_dropped_d;
        end
    end
endmodule

// File: tb/tb_uart_count_reporter.sv
// tb_uart_count_reporter: random and directed frames against a cycle-timed reference model
module tb_uart_count_reporter;
    typedef logic [7:0] byte_q [$];

    logic        clk = 1'b0;
    logic        rst, report_req, resp_pulse, stray;
    logic [15:0] count;
    logic        tx_done, tx_en, busy, frame_done, req_dropped;
    logic [7:0]  data_tx;

    int n_checks = 0, n_pass = 0;
    int cyc = 0, req_cyc = 0, first_launch = 0, fd_cnt = 0, drop_cnt = 0, resp_delay = 10;
    byte_q got;

    // reference model state
    bit        m_busy, m_fd, m_drop, m_txen, m_wait;
    logic [7:0] m_data;
    byte_q     m_bytes;
    int        m_idx, m_cd;

    assign tx_done = resp_pulse | stray;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_count_reporter dut (
        .clk         (clk),
        .rst         (rst),
        .report_req  (report_req),
        .count       (count),
        .tx_done     (tx_done),
        .tx_en       (tx_en),
        .data_tx     (data_tx),
        .busy        (busy),
        .frame_done  (frame_done),
        .req_dropped (req_dropped)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic byte_q term(input byte_q d);
        byte_q q = d;
`ifdef REPORT_CRLF_EN
        q.push_back(8'd13);
`endif
        q.push_back(8'd10);
        return q;
    endfunction

    function automatic byte_q fmt(input int v);
        string s = $sformatf("%0d", v);
        byte_q q = {};
        for (int i = 0; i < s.len(); i++) q.push_back(8'(s[i]));
        return term(q);
    endfunction

    task automatic chk_bytes(input string name, input byte_q e);
        chk({name, "_len"}, got.size(), e.size());
        for (int i = 0; i < e.size() && i < got.size(); i++)
            chk($sformatf("%s_b%0d", name, i), got[i], e[i]);
    endtask

    task automatic model_reset();
        m_busy = 0; m_fd = 0; m_drop = 0; m_txen = 1; m_wait = 0;
        m_data = 8'd0; m_idx = 0; m_cd = 0;
    endtask

    // advance the model by one clock edge given the inputs that edge samples
    task automatic model_step(input bit r, input bit d, input int c);
        bit pre_fd = m_fd, pre_busy = m_busy;
        m_fd = 0; m_drop = 0; m_txen = 1;
        if (m_wait && d) begin
            m_wait = 0;
            if (m_idx + 1 < m_bytes.size()) begin m_idx++; m_cd = 1; end
            else begin m_fd = 1; m_busy = 0; end
        end else if (m_cd > 0) begin
            m_cd--;
            if (m_cd == 0) begin m_txen = 0; m_data = m_bytes[m_idx]; m_wait = 1; end
        end
        if (r) begin
            if (pre_busy || pre_fd) m_drop = 1;
            else begin m_bytes = fmt(c); m_idx = 0; m_cd = 18; m_busy = 1; end
        end
    endtask

    // compare every cycle, then advance the model
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst) model_reset();
            chk("tx_en", tx_en, m_txen);
            chk("busy", busy, m_busy);
            chk("frame_done", frame_done, m_fd);
            chk("req_dropped", req_dropped, m_drop);
            chk("data_tx", data_tx, m_data);
            if (rst) model_step(report_req, tx_done, int'(count));
        end
    end

    // byte capture and pulse counting
    initial forever begin
        @(negedge clk);
        if (rst && tx_en === 1'b0) begin
            if (got.size() == 0) first_launch = cyc;
            got.push_back(data_tx);
        end
        if (frame_done === 1'b1) fd_cnt++;
        if (req_dropped === 1'b1) drop_cnt++;
    end

    // UART TX stand-in: answers each launch with tx_done after resp_delay cycles
    initial forever begin
        @(negedge clk);
        if (rst && tx_en === 1'b0) begin
            repeat (resp_delay) @(posedge clk);
            #1 resp_pulse = 1'b1;
            @(posedge clk);
            #1 resp_pulse = 1'b0;
        end
    end

    task automatic run_frame(input int c, input int budget, input int drop_at, input int stray_at, input bit req_on_fd);
        int n = 0;
        got.delete(); fd_cnt = 0; drop_cnt = 0;
        @(posedge clk);
        #1 count = 16'(c); report_req = 1'b1; req_cyc = cyc;
        @(posedge clk);
        #1 report_req = 1'b0;
        while (n < budget) begin
            @(posedge clk);
            #1 n++;
            if (frame_done) break;
            report_req = (n == drop_at);
            if (n == drop_at) count = ~count;
            stray = (n == stray_at);
        end
        chk("frame_done_seen", frame_done, 1);
        report_req = req_on_fd; stray = 1'b0;
        @(posedge clk);
        #1 report_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        byte_q lit;
        int c;
        rst = 1'b1; report_req = 1'b0; count = '0; resp_pulse = 1'b0; stray = 1'b0;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        chk("rst_tx_en", tx_en, 1);
        chk("rst_busy", busy, 0);
        chk("rst_data_tx", data_tx, 0);

        run_frame(1234, 400, 0, 0, 0);
        lit = '{8'd49, 8'd50, 8'd51, 8'd52};
        chk_bytes("f1234", term(lit));
        chk("first_launch_latency", first_launch - req_cyc - 1, 18);
        chk("f1234_frame_done_count", fd_cnt, 1);

        run_frame(0, 400, 0, 0, 0);
        lit = '{8'd48};
        chk_bytes("f0", term(lit));

        run_frame(65535, 400, 0, 0, 0);
        lit = '{8'd54, 8'd53, 8'd53, 8'd51, 8'd53};
        chk_bytes("f65535", term(lit));

        run_frame(42, 400, 0, 0, 0);
        lit = '{8'd52, 8'd50};
        chk_bytes("f42", term(lit));

        run_frame(1234, 400, 5, 0, 1);
        lit = '{8'd49, 8'd50, 8'd51, 8'd52};
        chk_bytes("fdrop", term(lit));
        chk("drop_count", drop_cnt, 2);

        // reset while waiting on the third byte
        got.delete();
        @(posedge clk);
        #1 count = 16'd1234; report_req = 1'b1;
        @(posedge clk);
        #1 report_req = 1'b0;
        for (int k = 0; k < 400 && got.size() < 3; k++) @(posedge clk);
        chk("rst_reach_b3", got.size(), 3);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("midrst_tx_en", tx_en, 1);
        chk("midrst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        run_frame(7, 400, 0, 0, 0);
        lit = '{8'd55};
        chk_bytes("f7_after_rst", term(lit));

        resp_delay = 1000;
        run_frame(7, 5000, 0, 3, 0);
        chk_bytes("f7_holdoff", term(lit));

        for (int f = 0; f < 30; f++) begin
            c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 120)) : int'($urandom_range(0, 65535));
            resp_delay = int'($urandom_range(1, 12));
            run_frame(c, 400, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 60)) : 0,
                      int'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
            chk_bytes($sformatf("rand%0d", f), fmt(c));
        end

        repeat (20) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
